// File: rtl/motor_pkg.sv
// motor_pkg: shared state encoding and coil tables for the stepper sequencer
// Contents: state_t, COIL_OFF, FULL_STEP_TBL, HALF_STEP_TBL, IDX_W, coil_pattern()
// Build option: HALF_STEP_EN selects the 8-entry half-step table and a 3-bit phase index
package motor_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [3:0] COIL_OFF = 4'b0000;
  localparam logic [0:3][3:0] FULL_STEP_TBL = {4'b1100, 4'b0110, 4'b0011, 4'b1001};
  localparam logic [0:7][3:0] HALF_STEP_TBL = {4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                               4'b0010, 4'b0011, 4'b0001, 4'b1001};
`ifdef HALF_STEP_EN
  localparam int IDX_W = 3;
`else
  localparam int IDX_W = 2;
`endif
  // Table length is 2^IDX_W, so the index wraps by plain overflow.
  function automatic logic [3:0] coil_pattern(input logic [IDX_W-1:0] i);
`ifdef HALF_STEP_EN
    return HALF_STEP_TBL[i];
`else
    return FULL_STEP_TBL[i];
`endif
  endfunction
endpackage

// File: rtl/stepper_sequencer_pulse_edge_sync.sv
// pulse_edge_sync: synchronise an asynchronous level and emit a one-cycle tick per rising edge
// Ports: i_clk clock, i_rst async active-high reset, i_pulse async level in, o_tick one-cycle rising-edge tick
module pulse_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pulse,
  output logic o_tick
);
  logic [STAGES-1:0] r_sync;
  logic r_prev;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pulse};
      r_prev <= r_sync[STAGES-1];
    end
  end
  assign o_tick = r_sync[STAGES-1] & ~r_prev;
endmodule

// File: rtl/stepper_sequencer.sv
// stepper_sequencer: steps a 4-coil stepper phase pattern once per rising edge of pulso_lento for a commanded move
// Ports: clock_100Mhz/reset (async, active-high); pulso_lento step pulse; cmd_valid/cmd_ready/cmd_steps/cmd_dir command;
//        abort, hold_en controls; coils pattern {A,B,C,D}; busy, done, position (signed, wraps), remaining status
// Build option: HALF_STEP_EN selects half-step sequencing
module stepper_sequencer
  import motor_pkg::*;
#(
  parameter int STEP_W      = 16,
  parameter int POS_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clock_100Mhz,
  input  logic                    reset,
  input  logic                    pulso_lento,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [STEP_W-1:0]       cmd_steps,
  input  logic                    cmd_dir,
  input  logic                    abort,
  input  logic                    hold_en,
  output logic [3:0]              coils,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position,
  output logic [STEP_W-1:0]       remaining
);
  state_t r_state, w_state_n;
  logic [IDX_W-1:0] r_idx, w_idx_n;
  logic [POS_W-1:0] r_pos, w_pos_n;
  logic [STEP_W-1:0] r_rem, w_rem_n;
  logic [3:0] r_coils, w_coils_n;
  logic r_dir, w_dir_n, w_tick, w_step;

  pulse_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk  (clock_100Mhz),
    .i_rst  (reset),
    .i_pulse(pulso_lento),
    .o_tick (w_tick)
  );

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_pos   <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_coils <= COIL_OFF;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_pos   <= w_pos_n;
      r_rem   <= w_rem_n;
      r_dir   <= w_dir_n;
      r_coils <= w_coils_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_rem_n   = r_rem;
    w_dir_n   = r_dir;
    // abort outranks a coincident tick
    w_step    = (r_state == RUN) && w_tick && !abort;
    case (r_state)
      IDLE: if (cmd_valid) begin
        w_dir_n   = cmd_dir;
        w_rem_n   = cmd_steps;
        w_state_n = (cmd_steps != '0) ? RUN : DONE;
      end
      RUN: if (abort) begin
        w_rem_n   = '0;
        w_state_n = DONE;
      end else if (w_tick) begin
        w_rem_n   = r_rem - STEP_W'(1);
        w_state_n = (r_rem == STEP_W'(1)) ? DONE : RUN;
      end
      default: w_state_n = IDLE;
    endcase
    w_idx_n   = w_step ? r_idx + (r_dir ? IDX_W'(1) : {IDX_W{1'b1}}) : r_idx;
    w_pos_n   = w_step ? r_pos + (r_dir ? POS_W'(1) : {POS_W{1'b1}}) : r_pos;
    // the final step of a move is always shown; afterwards hold_en decides
    w_coils_n = (w_state_n == RUN || w_step || hold_en) ? coil_pattern(w_idx_n) : COIL_OFF;
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign coils     = r_coils;
  assign position  = r_pos;
  assign remaining = r_rem;
endmodule

// File: tb/tb_stepper_sequencer.sv
// tb_stepper_sequencer: scoreboard bench for stepper_sequencer with a queue-based reference model
module tb_stepper_sequencer;
  logic clock_100Mhz = 1'b0, reset = 1'b1, pulso_lento = 1'b0, cmd_valid = 1'b0;
  logic cmd_dir = 1'b0, abort = 1'b0, hold_en = 1'b1;
  logic [15:0] cmd_steps = '0;
  logic cmd_ready, busy, done;
  logic [3:0] coils;
  logic signed [15:0] position;
  logic [15:0] remaining;

  stepper_sequencer dut (
    .clock_100Mhz(clock_100Mhz), .reset(reset), .pulso_lento(pulso_lento),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_steps(cmd_steps), .cmd_dir(cmd_dir),
    .abort(abort), .hold_en(hold_en), .coils(coils), .busy(busy), .done(done),
    .position(position), .remaining(remaining)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

`ifdef HALF_STEP_EN
  localparam int N = 8;
  logic [3:0] tbl [N] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
`else
  localparam int N = 4;
  logic [3:0] tbl [N] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
`endif

  int n_cmp = 0, n_bad = 0;
  int m_idx = 0, m_rem = 0;
  logic [15:0] m_pos = '0;
  bit m_dir, m_run, mon_en;
  logic [3:0] q_coil [$];
  logic [15:0] q_dpos [$];
  logic [3:0] prev_coils = 4'b0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clock_100Mhz) begin
    if (mon_en) begin
      if (coils !== prev_coils) begin
        if (q_coil.size() == 0) chk("coils_unexpected", {28'd0, coils}, {28'd0, prev_coils});
        else chk("coils", {28'd0, coils}, {28'd0, q_coil.pop_front()});
      end
      if (done) begin
        if (q_dpos.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else begin
          chk("done_pos", {16'd0, position}, {16'd0, q_dpos.pop_front()});
          chk("done_rem", {16'd0, remaining}, 32'd0);
          chk("done_busy", {31'd0, busy}, 32'd0);
        end
      end
    end
    prev_coils = coils;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock_100Mhz);
    #1;
  endtask

  task automatic finish_move();
    m_run = 0;
    q_dpos.push_back(m_pos);
    if (!hold_en) q_coil.push_back(4'b0000);
  endtask

  task automatic model_step();
    if (m_run) begin
      m_idx = (m_idx + (m_dir ? 1 : N - 1)) % N;
      m_pos = m_dir ? m_pos + 16'd1 : m_pos - 16'd1;
      q_coil.push_back(tbl[m_idx]);
      m_rem--;
      if (m_rem == 0) finish_move();
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!cmd_ready && t < 400) begin cyc(1); t++; end
    if (!cmd_ready) chk("idle_timeout", 32'd0, 32'd1);
    cyc(3);
    chk("coil_q_drained", q_coil.size(), 32'd0);
    chk("done_q_drained", q_dpos.size(), 32'd0);
  endtask

  task automatic issue(input int steps, input bit dir, input bit early);
    wait_idle();
    m_dir = dir;
    m_rem = steps;
    m_run = (steps != 0);
    if (steps == 0) q_dpos.push_back(m_pos);
    else if (!hold_en) q_coil.push_back(tbl[m_idx]);
    if (early) begin pulso_lento = 1'b1; cyc(2); end
    cmd_valid = 1'b1;
    cmd_steps = 16'(steps);
    cmd_dir = dir;
    cyc(1);
    cmd_valid = 1'b0;
    if (early) begin cyc(2); pulso_lento = 1'b0; cyc(4); end
  endtask

  task automatic pulse(input int hi, input int lo);
    model_step();
    pulso_lento = 1'b1;
    cyc(hi);
    pulso_lento = 1'b0;
    cyc(lo);
  endtask

  task automatic do_abort();
    if (m_run) begin m_rem = 0; finish_move(); end
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(2);
  endtask

  task automatic abort_on_tick();
    if (m_run) begin m_rem = 0; finish_move(); end
    pulso_lento = 1'b1;
    cyc(2);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(1);
    pulso_lento = 1'b0;
    cyc(4);
  endtask

  task automatic set_hold(input bit h);
    wait_idle();
    if (h != hold_en) q_coil.push_back(h ? tbl[m_idx] : 4'b0000);
    hold_en = h;
    cyc(3);
  endtask

  task automatic do_reset();
    @(negedge clock_100Mhz);
    mon_en = 0;
    #2 reset = 1'b1;
    #1;
    chk("rst_coils", {28'd0, coils}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pos", {16'd0, position}, 32'd0);
    chk("rst_rem", {16'd0, remaining}, 32'd0);
    q_coil.delete();
    q_dpos.delete();
    m_idx = 0; m_pos = '0; m_rem = 0; m_run = 0;
    pulso_lento = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
    cyc(2);
    if (hold_en) q_coil.push_back(tbl[0]);
    reset = 1'b0;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    mon_en = 1;
  endtask

  initial begin
    int steps, k;
    bit dir;
    cyc(3);
    do_reset();
    // reverse from idx 0, wrapping through zero
    issue(2, 1'b0, 1'b0);
    pulse(2, 5); pulse(3, 5);
    wait_idle();
    chk("rev_pos", {16'd0, position}, 32'h0000_FFFE);
    do_reset();
    // forward five steps, with a stray command mid-run that must be ignored
    issue(5, 1'b1, 1'b0);
    pulse(1, 4); pulse(2, 5);
    cmd_valid = 1'b1; cmd_steps = 16'd1; cyc(2); cmd_valid = 1'b0;
    chk("run_ready", {31'd0, cmd_ready}, 32'd0);
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_rem", {16'd0, remaining}, 32'd3);
    pulse(3, 4); pulse(1, 6); pulse(4, 4);
    wait_idle();
    chk("fwd_pos", {16'd0, position}, 32'd5);
    // abort coincident with the third tick
    issue(10, 1'b1, 1'b0);
    pulse(2, 5); pulse(2, 5);
    abort_on_tick();
    wait_idle();
    chk("abort_pos", {16'd0, position}, 32'd7);
    // zero-step command, early tick, long pulse
    issue(0, 1'b1, 1'b0);
    issue(2, 1'b0, 1'b1);
    pulse(2, 4); pulse(2, 4);
    wait_idle();
    chk("early_pos", {16'd0, position}, 32'd5);
    issue(3, 1'b1, 1'b0);
    pulse(100, 5); pulse(1, 5); pulse(2, 5);
    wait_idle();
    chk("long_pos", {16'd0, position}, 32'd8);
    set_hold(1'b0);
    chk("hold_off_coils", {28'd0, coils}, 32'd0);
    issue(2, 1'b1, 1'b0);
    pulse(2, 5); pulse(2, 5);
    wait_idle();
    chk("hold_off_after", {28'd0, coils}, 32'd0);
    set_hold(1'b1);
    // randomized moves
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 4) == 0) set_hold(1'($urandom_range(0, 1)));
      steps = $urandom_range(0, 6);
      dir = 1'($urandom_range(0, 1));
      issue(steps, dir, 1'($urandom_range(0, 3) == 0));
      if (steps >= 2 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, steps - 1);
        for (int p = 0; p < k; p++) pulse($urandom_range(1, 4), $urandom_range(4, 6));
        if ($urandom_range(0, 1) == 1) do_abort(); else abort_on_tick();
      end else begin
        k = steps + $urandom_range(0, 2);
        for (int p = 0; p < k; p++) pulse($urandom_range(1, 4), $urandom_range(4, 6));
      end
      wait_idle();
      chk("rand_pos", {16'd0, position}, {16'd0, m_pos});
    end
    // reset in the middle of a move
    set_hold(1'b1);
    issue(5, 1'b1, 1'b0);
    pulse(2, 5); pulse(2, 5);
    do_reset();
    cyc(5);
    chk("final_pos", {16'd0, position}, 32'd0);
    chk("final_q", q_coil.size() + q_dpos.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
